// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit saturating-counter BHT read at fetch, trained and resolved at execute.
// Optional macro BPU_PERF_CNT_EN adds branch and misprediction counters.
module branch_predict_unit #(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_f_pc,
  output logic            o_f_pred_taken,
  input  logic            i_x_valid,
  input  logic            i_x_branch,
  input  logic            i_x_jump,
  input  logic            i_x_zero,
  input  logic            i_x_sig,
  input  logic [2:0]      i_x_funct3,
  input  logic [XLEN-1:0] i_x_pc,
  input  logic            i_x_pred_taken,
  output logic            o_x_taken,
  output logic            o_x_mispredict
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]     o_br_count,
  output logic [31:0]     o_mispredict_count
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       bht [DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] x_idx;
  logic             br_taken;
  logic             br_legal;
  logic             bht_update;

  assign f_idx = i_f_pc[IDX_W+1:2];
  assign x_idx = i_x_pc[IDX_W+1:2];

  // Untagged table: only the index bits of either PC matter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_f_pc[XLEN-1:IDX_W+2], i_f_pc[1:0],
                            i_x_pc[XLEN-1:IDX_W+2], i_x_pc[1:0]};

  // No bypass: a same-cycle update is only seen by the next lookup.
  assign o_f_pred_taken = bht[f_idx][1];

  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (i_x_funct3)
      3'd0:          br_taken = i_x_zero;
      3'd1:          br_taken = ~i_x_zero;
      3'd4, 3'd6:    br_taken = i_x_sig;
      3'd5, 3'd7:    br_taken = ~i_x_sig;
      default:       br_legal = 1'b0;
    endcase
  end

  always_comb begin
    o_x_taken = 1'b0;
    if (i_x_valid) begin
      if (i_x_branch)    o_x_taken = br_taken;
      else if (i_x_jump) o_x_taken = 1'b1;
    end
  end

  assign o_x_mispredict = i_x_valid && (i_x_branch || i_x_jump) &&
                          (o_x_taken != i_x_pred_taken);

  assign bht_update = i_x_valid && i_x_branch && br_legal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= INIT_CNT;
    end else if (bht_update) begin
      if (br_taken && bht[x_idx] != 2'b11)
        bht[x_idx] <= bht[x_idx] + 2'b01;
      else if (!br_taken && bht[x_idx] != 2'b00)
        bht[x_idx] <= bht[x_idx] - 2'b01;
    end
  end

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_count         <= '0;
      o_mispredict_count <= '0;
    end else begin
      if (i_x_valid && i_x_branch) o_br_count <= o_br_count + 32'd1;
      if (o_x_mispredict)          o_mispredict_count <= o_mispredict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomized traffic against an ISA-level model.
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int IDX_W = 6;
  localparam int DEPTH = 1 << IDX_W;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] f_pc;
  logic            f_pred_taken;
  logic            x_valid, x_branch, x_jump, x_zero, x_sig, x_pred_taken;
  logic [2:0]      x_funct3;
  logic [XLEN-1:0] x_pc;
  logic            x_taken, x_mispredict;
`ifdef BPU_PERF_CNT_EN
  logic [31:0]     br_count, mispredict_count;
`endif

  // Operands the ALU would have compared; flags are derived from these.
  logic [XLEN-1:0] op_a, op_b;

  int tests_run = 0;
  int tests_failed = 0;
  int model_bht [DEPTH];

  branch_predict_unit #(.XLEN(XLEN), .IDX_W(IDX_W), .INIT_CNT(2'b01)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_f_pc(f_pc), .o_f_pred_taken(f_pred_taken),
    .i_x_valid(x_valid), .i_x_branch(x_branch), .i_x_jump(x_jump),
    .i_x_zero(x_zero), .i_x_sig(x_sig), .i_x_funct3(x_funct3), .i_x_pc(x_pc),
    .i_x_pred_taken(x_pred_taken), .o_x_taken(x_taken), .o_x_mispredict(x_mispredict)
`ifdef BPU_PERF_CNT_EN
    , .o_br_count(br_count), .o_mispredict_count(mispredict_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_bht[i] = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Instruction semantics: BEQ/BNE/BLT/BGE/BLTU/BGEU on the real operands.
  function automatic bit ref_taken(bit v, bit br, bit jp, logic [2:0] f3,
                                   logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    if (!v) return 1'b0;
    if (br) begin
      case (f3)
        3'd0: return a == b;
        3'd1: return a != b;
        3'd4: return $signed(a) <  $signed(b);
        3'd5: return $signed(a) >= $signed(b);
        3'd6: return a <  b;
        3'd7: return a >= b;
        default: return 1'b0;
      endcase
    end
    return jp;
  endfunction

  function automatic bit ref_pred(logic [XLEN-1:0] pc);
    return model_bht[(pc >> 2) % DEPTH] >= 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(bit v, bit br, bit jp, logic [2:0] f3, logic [XLEN-1:0] a,
                       logic [XLEN-1:0] b, logic [XLEN-1:0] xpc, bit pred,
                       logic [XLEN-1:0] fpc);
    @(negedge clk);
    x_valid = v; x_branch = br; x_jump = jp; x_funct3 = f3;
    op_a = a; op_b = b;
    x_zero = (a == b);
    x_sig  = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    x_pc = xpc; x_pred_taken = pred; f_pc = fpc;
    #1;
  endtask

  task automatic drive_idle(logic [XLEN-1:0] fpc);
    drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0, fpc);
  endtask

  // Advance one edge and train the model from the driven instruction.
  task automatic clock_update();
    bit t;
    int idx;
    @(posedge clk);
    t = ref_taken(x_valid, x_branch, x_jump, x_funct3, op_a, op_b);
    idx = (x_pc >> 2) % DEPTH;
    if (x_valid && x_branch && x_funct3 != 3'd2 && x_funct3 != 3'd3) begin
      if (t) model_bht[idx] = (model_bht[idx] == 3) ? 3 : model_bht[idx] + 1;
      else   model_bht[idx] = (model_bht[idx] == 0) ? 0 : model_bht[idx] - 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    drive_idle(32'h100);
    tests_run++;
    if (f_pred_taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pred_0x100 got=%b exp=0", f_pred_taken);
    end
    tests_run++;
    if (x_taken !== 1'b0 || x_mispredict !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_outputs got taken=%b mis=%b exp=0/0", x_taken, x_mispredict);
    end
    for (int i = 0; i < DEPTH; i++) begin
      f_pc = XLEN'(i) << 2;
      #1;
      tests_run++;
      if (f_pred_taken !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_sweep idx=%0d got=%b exp=0", i, f_pred_taken);
      end
    end
  endtask

  task automatic test_saturate_up();
    bit exp_lookup [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd7, 32'd7, 32'h100, 1'b0, 32'h100);
      tests_run++;
      if (x_taken !== 1'b1 || f_pred_taken !== exp_lookup[i]) begin
        tests_failed++;
        $display("FAIL beq_up step=%0d got taken=%b pred=%b exp taken=1 pred=%b",
                 i, x_taken, f_pred_taken, exp_lookup[i]);
      end
      if (i == 0) begin
        tests_run++;
        if (x_mispredict !== 1'b1) begin
          tests_failed++;
          $display("FAIL beq_up_mispredict got=%b exp=1", x_mispredict);
        end
      end
      clock_update();
    end
    drive_idle(32'h100);
    tests_run++;
    if (f_pred_taken !== 1'b1) begin
      tests_failed++;
      $display("FAIL beq_up_final got=%b exp=1", f_pred_taken);
    end
  endtask

  task automatic test_saturate_down();
    // Counter 11 -> 10 -> 01 -> 00, then one taken update: 00 -> 01 still predicts 0.
    bit exp_lookup [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd1, 32'd3, 32'd3, 32'h100, 1'b1, 32'h100);
      tests_run++;
      if (x_taken !== 1'b0 || x_mispredict !== 1'b1 || f_pred_taken !== exp_lookup[i]) begin
        tests_failed++;
        $display("FAIL bne_down step=%0d got taken=%b mis=%b pred=%b exp 0/1/%b",
                 i, x_taken, x_mispredict, f_pred_taken, exp_lookup[i]);
      end
      clock_update();
    end
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd1, 32'd1, 32'h100, 1'b0, 32'h100);
    tests_run++;
    if (f_pred_taken !== exp_lookup[3]) begin
      tests_failed++;
      $display("FAIL bne_down_final got=%b exp=0", f_pred_taken);
    end
    clock_update();
    drive_idle(32'h100);
    tests_run++;
    if (f_pred_taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL bne_floor_held got=%b exp=0", f_pred_taken);
    end
  endtask

  task automatic test_jump_illegal();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h40, 1'b0, 32'h40);
    clock_update();   // idx 16 -> 10
    drive(1'b1, 1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 32'h40, 1'b0, 32'h40);
    tests_run++;
    if (x_taken !== 1'b1 || x_mispredict !== 1'b1) begin
      tests_failed++;
      $display("FAIL jump got taken=%b mis=%b exp=1/1", x_taken, x_mispredict);
    end
    clock_update();
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'd1, 32'd2, 32'h40, 1'b0, 32'h40);
    tests_run++;
    if (x_taken !== 1'b0 || x_mispredict !== 1'b0) begin
      tests_failed++;
      $display("FAIL funct3_2 got taken=%b mis=%b exp=0/0", x_taken, x_mispredict);
    end
    clock_update();
    drive(1'b1, 1'b1, 1'b1, 3'd3, 32'd5, 32'd5, 32'h40, 1'b1, 32'h40);
    tests_run++;
    if (x_taken !== 1'b0 || x_mispredict !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_over_jump got taken=%b mis=%b exp=0/1", x_taken, x_mispredict);
    end
    clock_update();
    // Counter must still be 10: one not-taken update would drop it to 01.
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'd0, 32'd0, 32'h40, 1'b1, 32'h40);
    clock_update();
    drive_idle(32'h40);
    tests_run++;
    if (f_pred_taken !== 1'b0 || f_pred_taken !== ref_pred(32'h40)) begin
      tests_failed++;
      $display("FAIL jump_no_update got=%b exp=0", f_pred_taken);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd9, 32'd9, 32'h14, 1'b0, 32'h14);
    tests_run++;
    if (f_pred_taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_no_bypass got=%b exp=0", f_pred_taken);
    end
    clock_update();
    drive_idle(32'h14);
    tests_run++;
    if (f_pred_taken !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_next got=%b exp=1", f_pred_taken);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (f_pred_taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_restore got=%b exp=0", f_pred_taken);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit v, br, jp, pred, et;
    logic [2:0] f3;
    logic [XLEN-1:0] a, b, xpc, fpc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 9) != 0);
      br = ($urandom_range(0, 3) != 0);
      jp = ($urandom_range(0, 4) == 0);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      // Few PCs so counters saturate and alias.
      xpc = {$urandom_range(0, 3), 6'd0, 3'($urandom_range(0, 7)), 2'b00};
      fpc = {$urandom_range(0, 3), 6'd0, 3'($urandom_range(0, 7)), 2'b00};
      pred = ref_pred(xpc);
      drive(v, br, jp, f3, a, b, xpc, pred, fpc);
      et = ref_taken(v, br, jp, f3, a, b);
      tests_run++;
      if (x_taken !== et || x_mispredict !== (v && (br || jp) && et != pred) ||
          f_pred_taken !== ref_pred(fpc)) begin
        tests_failed++;
        $display("FAIL random n=%0d got taken=%b mis=%b pred=%b exp taken=%b mis=%b pred=%b",
                 n, x_taken, x_mispredict, f_pred_taken, et,
                 v && (br || jp) && et != pred, ref_pred(fpc));
      end
      clock_update();
    end
  endtask

`ifdef BPU_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd2, 32'd2, 32'h200, (i >= 3), 32'h0);
      clock_update();
    end
    drive_idle(32'h0);
    tests_run++;
    if (br_count !== 32'd10 || mispredict_count !== 32'd3) begin
      tests_failed++;
      $display("FAIL perf_counts got br=%0d mis=%0d exp=10/3", br_count, mispredict_count);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    f_pc = '0; x_valid = 0; x_branch = 0; x_jump = 0; x_zero = 0; x_sig = 0;
    x_funct3 = '0; x_pc = '0; x_pred_taken = 0; op_a = '0; op_b = '0;
    model_reset();
    test_reset();
    test_saturate_up();
    test_saturate_down();
    test_jump_illegal();
    test_same_cycle_and_reset();
    test_random();
`ifdef BPU_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
